// File: rtl/mult_dispatch.sv
// mult_dispatch: buffers multiply requests and issues them one at a time to a sequential multiplier.
// Optional watchdog: define MULT_DISPATCH_TIMEOUT_EN to abandon a multiply after TIMEOUT cycles in WAIT.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake; req_m, req_q signed operands, req_tag identifier
//   mul_start, mul_m, mul_q         start pulse and held operands to the multiplier
//   mul_product, mul_valid          multiplier result and done strobe
//   rsp_valid/rsp_ready             response handshake; rsp_product, rsp_tag, rsp_err (watchdog expiry)
//   busy                            FIFO non-empty or a request in progress
module mult_dispatch #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 2*WIDTH+8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_m,
    input  logic [WIDTH-1:0]   req_q,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_m,
    output logic [WIDTH-1:0]   mul_q,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_valid,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_err,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] fifo_m [DEPTH];
    logic [WIDTH-1:0] fifo_q [DEPTH];
    logic [TAG_W-1:0] fifo_t [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [TAG_W-1:0] tag;
    logic             full, empty, push, pop, capture, expire;

    assign full      = count == FULL_CNT;
    assign empty     = count == '0;
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = state == IDLE && !empty;
    assign capture   = state == WAIT && mul_valid;
    assign mul_start = state == ISSUE;
    assign rsp_valid = state == RESP;
    assign busy      = !empty || state != IDLE;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = empty ? IDLE : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = (capture || expire) ? RESP : WAIT;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_m[wr_ptr] <= req_m;
            fifo_q[wr_ptr] <= req_q;
            fifo_t[wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mul_m       <= '0;
            mul_q       <= '0;
            tag         <= '0;
            rsp_product <= '0;
            rsp_tag     <= '0;
        end else begin
            state <= state_next;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                mul_m  <= fifo_m[rd_ptr];
                mul_q  <= fifo_q[rd_ptr];
                tag    <= fifo_t[rd_ptr];
            end
            if (capture || expire) begin
                rsp_product <= capture ? mul_product : '0;
                rsp_tag     <= tag;
            end
        end
    end

`ifdef MULT_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT-1);

    logic [CW-1:0] wait_cnt;
    logic          err;

    // Counter holds the number of WAIT cycles already spent; expiry fires on the
    // TIMEOUT-th WAIT cycle, and a simultaneous mul_valid takes priority.
    assign expire  = state == WAIT && !mul_valid && wait_cnt == LIMIT;
    assign rsp_err = err;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + CW'(1);
            if (expire)
                err <= 1'b1;
            else if (state == RESP && rsp_ready)
                err <= 1'b0;
        end
    end
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule
